// File: rtl/add_pkg.sv
// add_pkg: shared flag indices and result record for the adder result stage
package add_pkg;
  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
  localparam int FLAG_W = 4;
  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [7:0]        data;
  } add_res_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH x WIDTH synchronous FIFO whose output holds the last popped word when empty
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign rdata = empty ? last_q : mem_q[rd_ptr_q];
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    last_d   = do_pop ? mem_q[rd_ptr_q] : last_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end
endmodule

// File: rtl/add_result_stage.sv
// add_result_stage: derives C/Z/N/V for each adder result, buffers it, and counts carry/overflow events
module add_result_stage
  import add_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       sum_in,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [3:0]       out_flags,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] carry_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);
  add_res_t         res_in, res_out;
  logic             full, empty, push, pop;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d, ovf_cnt_q, ovf_cnt_d;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = res_out.data;
  assign out_flags = res_out.flags;
  assign carry_cnt = carry_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;
  always_comb begin
    res_in              = '0;
    res_in.data         = sum_in[7:0];
    res_in.flags[FLG_C] = sum_in[8];
    res_in.flags[FLG_Z] = sum_in[7:0] == 8'h00;
    res_in.flags[FLG_N] = sum_in[7];
    res_in.flags[FLG_V] = (a_msb == b_msb) && (sum_in[7] != a_msb);
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;
    carry_cnt_d = clr_cnt ? '0
                : (push && res_in.flags[FLG_C] && !(&carry_cnt_q)) ? carry_cnt_q + CNT_W'(1)
                : carry_cnt_q;
    ovf_cnt_d   = clr_cnt ? '0
                : (push && res_in.flags[FLG_V] && !(&ovf_cnt_q)) ? ovf_cnt_q + CNT_W'(1)
                : ovf_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_cnt_q <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      carry_cnt_q <= carry_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end
  sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(add_res_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (res_in),
    .pop   (pop),
    .rdata (res_out),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_add_result_stage.sv
// tb_add_result_stage: directed vector table plus hand-written handshake, wrap, saturation and reset sequences
module tb_add_result_stage;
  logic       clk = 0, rst_n = 0, in_valid = 0, in_ready, a_msb = 0, b_msb = 0;
  logic       out_valid, out_ready = 0, clr_cnt = 0;
  logic [8:0] sum_in = '0;
  logic [7:0] out_data, carry_cnt, ovf_cnt;
  logic [3:0] out_flags;
  int         n_pass = 0, n_total = 0;
  int         ec = 0, ev = 0;
  typedef struct {
    logic [8:0] sum;
    logic       a, b;
    logic [7:0] d;
    logic [3:0] f;
  } vec_t;
  vec_t vt [6];
  add_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sum_in(sum_in),
    .a_msb(a_msb), .b_msb(b_msb), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .clr_cnt(clr_cnt),
    .carry_cnt(carry_cnt), .ovf_cnt(ovf_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic drive(input logic v, input logic [8:0] s, input logic a, input logic b);
    in_valid = v;
    sum_in   = s;
    a_msb    = a;
    b_msb    = b;
  endtask
  initial begin
    vt[0] = '{9'h100, 1'b1, 1'b1, 8'h00, 4'b1011};
    vt[1] = '{9'h080, 1'b0, 1'b0, 8'h80, 4'b1100};
    vt[2] = '{9'h000, 1'b0, 1'b0, 8'h00, 4'b0010};
    vt[3] = '{9'h1FF, 1'b1, 1'b1, 8'hFF, 4'b0101};
    vt[4] = '{9'h07F, 1'b0, 1'b1, 8'h7F, 4'b0000};
    vt[5] = '{9'h17F, 1'b1, 1'b1, 8'h7F, 4'b1001};
    tick;
    tick;
    rst_n = 1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_carry_cnt", carry_cnt, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      drive(1, vt[i].sum, vt[i].a, vt[i].b);
      ec += int'(vt[i].f[0]);
      ev += int'(vt[i].f[3]);
      tick;
      in_valid = 0;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].d);
      chk($sformatf("vec%0d_flags", i), out_flags, vt[i].f);
      chk($sformatf("vec%0d_carry_cnt", i), carry_cnt, ec);
      chk($sformatf("vec%0d_ovf_cnt", i), ovf_cnt, ev);
      tick;
      chk($sformatf("vec%0d_drained", i), out_valid, 0);
      chk($sformatf("vec%0d_hold_data", i), out_data, vt[i].d);
      chk($sformatf("vec%0d_hold_flags", i), out_flags, vt[i].f);
    end
    out_ready = 0;
    drive(1, 9'h011, 0, 0);
    tick;
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_data", out_data, 8'h11);
    chk("bp_ready_after_1", in_ready, 1);
    drive(1, 9'h022, 0, 0);
    tick;
    chk("bp_full_ready", in_ready, 0);
    drive(1, 9'h033, 0, 0);
    tick;
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_stall_data", out_data, 8'h11);
    out_ready = 1;
    tick;
    chk("bp_second_data", out_data, 8'h22);
    chk("bp_ready_after_pop", in_ready, 1);
    chk("bp_second_valid", out_valid, 1);
    in_valid = 0;
    tick;
    chk("bp_empty", out_valid, 0);
    chk("bp_no_third", out_data, 8'h22);
    for (int i = 0; i < 10; i++) begin
      drive(1, 9'(i * 7 + 3), 0, 0);
      tick;
      chk($sformatf("stream%0d_valid", i), out_valid, 1);
      chk($sformatf("stream%0d_data", i), out_data, 32'(i * 7 + 3));
      chk($sformatf("stream%0d_ready", i), in_ready, 1);
    end
    in_valid = 0;
    tick;
    chk("stream_drained", out_valid, 0);
    chk("stream_carry_cnt", carry_cnt, ec);
    for (int i = ec; i < 255; i++) begin
      drive(1, 9'h100, 0, 1);
      tick;
    end
    chk("sat_reach_255", carry_cnt, 255);
    tick;
    chk("sat_hold_255", carry_cnt, 255);
    chk("sat_ovf_unchanged", ovf_cnt, ev);
    clr_cnt = 1;
    tick;
    clr_cnt = 0;
    in_valid = 0;
    chk("clr_carry_cnt", carry_cnt, 0);
    chk("clr_ovf_cnt", ovf_cnt, 0);
    tick;
    out_ready = 0;
    drive(1, 9'h155, 0, 0);
    tick;
    drive(1, 9'h066, 0, 0);
    tick;
    in_valid = 0;
    chk("pre_rst_full", in_ready, 0);
    chk("pre_rst_carry_cnt", carry_cnt, 1);
    rst_n = 0;
    tick;
    rst_n = 1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_flags", out_flags, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_carry_cnt", carry_cnt, 0);
    chk("mid_rst_ovf_cnt", ovf_cnt, 0);
    out_ready = 1;
    tick;
    chk("mid_rst_stays_empty", out_valid, 0);
    chk("mid_rst_data_zero", out_data, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
